// File: rtl/inst_encoder_loader.sv
// Program loader: packs symbolic RV64 requests (R-type, LD, SD, BEQ) into 32-bit
// instruction words and writes them into imem at consecutive word addresses.
module inst_encoder_loader #(
   parameter int                ADDR_W    = 8,
   parameter int                DEPTH     = 256,
   parameter logic [ADDR_W+1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [12:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W+1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err_align,
   output logic              err_range,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENC   = 2'd1,
      WRITE = 2'd2,
      FULL  = 2'd3
   } state_t;

   localparam logic [1:0] KIND_R  = 2'b00;
   localparam logic [1:0] KIND_LD = 2'b01;
   localparam logic [1:0] KIND_SD = 2'b10;
   localparam logic [1:0] KIND_BEQ = 2'b11;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [ADDR_W:0] depth_c = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   count_inc;

   logic [1:0]  kind_q;
   logic [4:0]  rd_q;
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic [2:0]  funct3_q;
   logic [6:0]  funct7_q;
   logic [12:0] imm_q;

   logic [31:0] enc_word;
   logic        enc_misalign;
   logic        enc_outrange;

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // the producer holds all in_* fields stable while in_valid is high and unaccepted.
   assign in_ready  = (state == IDLE) && !full;
   assign dbg_state = state;
   assign mem_addr  = BASE_ADDR + {ptr, 2'b00};
   assign count_inc = count + 1'b1;

   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         kind_q   <= in_kind;
         rd_q     <= in_rd;
         rs1_q    <= in_rs1;
         rs2_q    <= in_rs2;
         funct3_q <= in_funct3;
         funct7_q <= in_funct7;
         imm_q    <= in_imm;
      end
   end

   always_comb begin
      enc_word     = '0;
      enc_misalign = 1'b0;
      enc_outrange = 1'b0;
      case (kind_q)
         KIND_R: begin
            enc_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, OP_R};
         end
         KIND_LD: begin
            enc_word     = {imm_q[11:0], rs1_q, funct3_q, rd_q, OP_LD};
            enc_outrange = imm_q[12] != imm_q[11];
         end
         KIND_SD: begin
            enc_word     = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], OP_SD};
            enc_outrange = imm_q[12] != imm_q[11];
         end
         KIND_BEQ: begin
            // imm[0] has no slot in the B format; a set bit is dropped and flagged.
            enc_word     = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                            imm_q[4:1], imm_q[11], OP_BEQ};
            enc_misalign = imm_q[0];
         end
         default: begin
            enc_word = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         ptr       <= '0;
         count     <= '0;
         full      <= 1'b0;
         err_align <= 1'b0;
         err_range <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state <= ENC;
               end
            end
            ENC: begin
               mem_wdata <= enc_word;
               mem_we    <= 1'b1;
               err_align <= err_align | enc_misalign;
               err_range <= err_range | enc_outrange;
               state     <= WRITE;
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_we <= 1'b0;
                  count  <= count_inc;
                  // The pointer stays on the last word once the memory is full.
                  if (count_inc == depth_c) begin
                     full  <= 1'b1;
                     state <= FULL;
                  end else begin
                     ptr   <= ptr + 1'b1;
                     state <= IDLE;
                  end
               end
            end
            FULL: begin
               state <= FULL;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: hand-computed instruction words checked
// by a scoreboard monitor; control/boundary behaviour checked inline.
module tb_inst_encoder_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [12:0]       in_imm;
   logic              mem_we;
   logic [ADDR_W+1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err_align;
   logic              err_range;
   logic [1:0]        dbg_state;

   logic [41:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_cnt = 0;
   int          exp_ptr = 0;

   inst_encoder_loader #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .BASE_ADDR(10'h000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_kind  (in_kind),
      .in_rd    (in_rd),
      .in_rs1   (in_rs1),
      .in_rs2   (in_rs2),
      .in_funct3(in_funct3),
      .in_funct7(in_funct7),
      .in_imm   (in_imm),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .count    (count),
      .full     (full),
      .err_align(err_align),
      .err_range(err_range),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: every accepted write is popped and compared
   initial begin
      logic [41:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && !clear && mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write",
                        mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(e[41:32]));
               check("wr_data", mem_wdata, e[31:0]);
            end
         end
      end
   end

   // driver: one request, optional ack stall, then post-write checks
   task automatic send(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [12:0] imm, input logic [31:0] word, input int stall);
      int n = 0;
      logic [9:0] addr;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      if (!in_ready) return;
      addr = 10'(exp_ptr * 4);
      exp_q.push_back({addr, word});
      in_kind = kind; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("enc_in_ready", 32'(in_ready), 32'd0);
      step();
      check("write_mem_we", 32'(mem_we), 32'd1);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         in_kind  = 2'b00;
         in_rd    = 5'd31;
         mem_ack  = 1'b0;
         step();
         check("stall_mem_we", 32'(mem_we), 32'd1);
         check("stall_addr", 32'(mem_addr), 32'(addr));
         check("stall_data", mem_wdata, word);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      mem_ack  = 1'b1;
      step();
      mem_ack  = 1'b0;
      exp_cnt++;
      if (exp_cnt < DEPTH) exp_ptr++;
      check("count", 32'(count), 32'(exp_cnt));
      check("mem_we_drop", 32'(mem_we), 32'd0);
      check("ready_after", 32'(in_ready), 32'(exp_cnt < DEPTH));
      check("full", 32'(full), 32'(exp_cnt == DEPTH));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      exp_cnt = 0;
      exp_ptr = 0;
      check("clr_count", 32'(count), 32'd0);
      check("clr_full", 32'(full), 32'd0);
      check("clr_err_align", 32'(err_align), 32'd0);
      check("clr_err_range", 32'(err_range), 32'd0);
      check("clr_addr", 32'(mem_addr), 32'd0);
      check("clr_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
      in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      step();
      step();
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_err_align", 32'(err_align), 32'd0);
      check("rst_err_range", 32'(err_range), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // R-type add x3,x1,x2
      send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 32'h002081B3, 0);

      // LD then SD
      do_clear();
      send(2'b01, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 13'd8,  32'h00813283, 0);
      send(2'b10, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, 13'd16, 32'h00513823, 0);
      check("ldsd_err_range", 32'(err_range), 32'd0);

      // BEQ, aligned then misaligned offset
      do_clear();
      send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8, 32'hFE208CE3, 0);
      check("beq_err_align0", 32'(err_align), 32'd0);
      send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0009, 32'h00208463, 0);
      check("beq_err_align1", 32'(err_align), 32'd1);

      // ack held low for 5 cycles
      send(2'b00, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 13'd0, 32'h40628233, 5);

      // fill to DEPTH, then a dropped request
      do_clear();
      send(2'b00, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 13'd0, 32'h003100B3, 0);
      send(2'b00, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 13'd0, 32'h40628233, 0);
      send(2'b01, 5'd7, 5'd8, 5'd0, 3'd3, 7'd0, 13'h1FF8, 32'hFF843383, 0);
      send(2'b10, 5'd0, 5'd10, 5'd9, 3'd3, 7'd0, 13'h1FFC, 32'hFE953E23, 0);
      check("full_err_range", 32'(err_range), 32'd0);
      in_valid = 1'b1; in_kind = 2'b00; in_rd = 5'd9;
      for (int i = 0; i < 4; i++) begin
         step();
         check("full_mem_we", 32'(mem_we), 32'd0);
         check("full_in_ready", 32'(in_ready), 32'd0);
         check("full_state", 32'(dbg_state), 32'd3);
      end
      in_valid = 1'b0;
      check("full_count", 32'(count), 32'd4);
      do_clear();
      send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 32'h002081B3, 0);

      // reset during WRITE with a coincident ack
      do_clear();
      send(2'b01, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800, 32'h80000083, 0);
      check("ld_err_range", 32'(err_range), 32'd1);
      in_kind = 2'b11; in_rs1 = 5'd1; in_rs2 = 5'd2; in_funct3 = 3'd0; in_imm = 13'h0009;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("pre_rst_mem_we", 32'(mem_we), 32'd1);
      check("pre_rst_err_align", 32'(err_align), 32'd1);
      check("pre_rst_state", 32'(dbg_state), 32'd2);
      rst_n = 1'b0;
      mem_ack = 1'b1;
      step();
      check("rstw_mem_we", 32'(mem_we), 32'd0);
      check("rstw_count", 32'(count), 32'd0);
      check("rstw_err_align", 32'(err_align), 32'd0);
      check("rstw_err_range", 32'(err_range), 32'd0);
      check("rstw_state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      mem_ack = 1'b0;
      exp_cnt = 0;
      exp_ptr = 0;
      step();
      step();
      check("rstw_idle_mem_we", 32'(mem_we), 32'd0);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
